wb_rr_arbiter: RTL and testbench

- Three-master round-robin Wishbone arbiter for the upper core's single external 16-bit bus.
- Masters: m0 = dcache, m1 = icache, m2 = debug/DMA port.
- Grants one master per bus tenure. Tenures may be single or burst (4/8 beats), and burst flags are passed through.
- A watchdog terminates a stalled transfer with a generated error, so a dead slave cannot hang the core.

---
 rtl/wb_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Three-master round-robin Wishbone arbiter with burst pass-through and a
// stall watchdog. m0 = dcache, m1 = icache, m2 = debug/DMA.
// A grant is held for the whole tenure (m_cyc of the owner high). A stalled
// strobe is terminated with a generated error after TIMEOUT unanswered cycles.
// TIMEOUT must be >= 2 and fit in 8 bits.
module wb_rr_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [2:0]          m_cyc,
  input  logic [2:0]          m_stb,
  input  logic [2:0]          m_we,
  input  logic [3*ADDR_W-1:0] m_adr,
  input  logic [3*DATA_W-1:0] m_o_dat,
  input  logic [3*SEL_W-1:0]  m_sel,
  input  logic [2:0]          m_4_burst,
  input  logic [2:0]          m_8_burst,
  output logic [2:0]          m_ack,
  output logic [2:0]          m_err,
  output logic                owb_cyc,
  output logic                owb_stb,
  output logic                owb_we,
  output logic [ADDR_W-1:0]   owb_adr,
  output logic [DATA_W-1:0]   owb_o_dat,
  output logic [SEL_W-1:0]    owb_sel,
  output logic                owb_4_burst,
  output logic                owb_8_burst,
  input  logic                owb_ack,
  input  logic                owb_err,
  output logic [1:0]          o_grant,
  output logic                o_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_ABORT} state_t;

  localparam logic [1:0] NO_GRANT  = 2'd3;
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  grant_reg, grant_next;
  logic [1:0]  last_reg, last_next;
  logic [7:0]  wdog_reg, wdog_next;
  logic        timeout_reg, fire;
  logic [1:0]  cand_a, cand_b, pick;

  logic [ADDR_W-1:0] adr_arr [3];
  logic [DATA_W-1:0] dat_arr [3];
  logic [SEL_W-1:0]  sel_arr [3];

  // Unpack the flat per-master buses so the grant mux is a plain array index.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
      assign adr_arr[gi] = m_adr[gi*ADDR_W +: ADDR_W];
      assign dat_arr[gi] = m_o_dat[gi*DATA_W +: DATA_W];
      assign sel_arr[gi] = m_sel[gi*SEL_W +: SEL_W];
    end
  endgenerate

  // Modulo-3 successor of a master index.
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Round-robin pick: search last+1, last+2, then last itself.
  always_comb begin
    cand_a = rr_next(last_reg);
    cand_b = rr_next(cand_a);
    pick   = NO_GRANT;
    if (m_cyc[cand_a])
      pick = cand_a;
    else if (m_cyc[cand_b])
      pick = cand_b;
    else if (m_cyc[last_reg])
      pick = last_reg;
  end

  // Bus mux and response routing; everything is zero unless a live owner exists.
  always_comb begin
    owb_cyc     = 1'b0;
    owb_stb     = 1'b0;
    owb_we      = 1'b0;
    owb_adr     = '0;
    owb_o_dat   = '0;
    owb_sel     = '0;
    owb_4_burst = 1'b0;
    owb_8_burst = 1'b0;
    m_ack       = 3'b000;
    m_err       = 3'b000;
    o_grant     = (state_reg == ST_IDLE) ? NO_GRANT : grant_reg;
    o_timeout   = timeout_reg;
    case (state_reg)
      ST_OWN: begin
        // Owner dropping cyc releases the bus in the same cycle.
        if (m_cyc[grant_reg]) begin
          owb_cyc            = 1'b1;
          owb_stb            = m_stb[grant_reg];
          owb_we             = m_we[grant_reg];
          owb_adr            = adr_arr[grant_reg];
          owb_o_dat          = dat_arr[grant_reg];
          owb_sel            = sel_arr[grant_reg];
          owb_4_burst        = m_4_burst[grant_reg];
          owb_8_burst        = m_8_burst[grant_reg];
          m_ack[grant_reg]   = owb_ack;
          m_err[grant_reg]   = owb_err;
        end
      end
      ST_ABORT: begin
        // Only the first ABORT cycle carries the generated error; slave acks are dropped.
        m_err[grant_reg] = timeout_reg;
      end
      default: ;
    endcase
  end

  // Next-state, grant bookkeeping and watchdog counting.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    wdog_next  = 8'd0;
    fire       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick != NO_GRANT) begin
          grant_next = pick;
          last_next  = pick;
          state_next = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!m_cyc[grant_reg]) begin
          state_next = ST_IDLE;
          grant_next = NO_GRANT;
        end else if (owb_stb && !owb_ack && !owb_err) begin
          // A response in the would-be firing cycle wins, so only an
          // unanswered strobe at the last count fires.
          if (wdog_reg == WDOG_LAST) begin
            fire       = 1'b1;
            state_next = ST_ABORT;
          end else if (wdog_reg != 8'hFF) begin
            wdog_next = wdog_reg + 8'd1;
          end else begin
            wdog_next = wdog_reg;
          end
        end
      end
      ST_ABORT: begin
        if (!m_cyc[grant_reg]) begin
          state_next = ST_IDLE;
          grant_next = NO_GRANT;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = NO_GRANT;
      end
    endcase
  end

  // State register; reset gives m0 first priority (last = 2).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= NO_GRANT;
      last_reg    <= 2'd2;
      wdog_reg    <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      wdog_reg    <= wdog_next;
      timeout_reg <= fire;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: single request, contention order, burst
// hold, watchdog fire, late-ack race and async reset mid-burst.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_wb_rr_arbiter;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 16;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [2:0]          m_cyc, m_stb, m_we, m_4_burst, m_8_burst;
  logic [3*ADDR_W-1:0] m_adr;
  logic [3*DATA_W-1:0] m_o_dat;
  logic [3*SEL_W-1:0]  m_sel;
  logic [2:0]          m_ack, m_err;
  logic                owb_cyc, owb_stb, owb_we, owb_4_burst, owb_8_burst;
  logic [ADDR_W-1:0]   owb_adr;
  logic [DATA_W-1:0]   owb_o_dat;
  logic [SEL_W-1:0]    owb_sel;
  logic                owb_ack, owb_err;
  logic [1:0]          o_grant;
  logic                o_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  wb_rr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_o_dat(m_o_dat), .m_sel(m_sel), .m_4_burst(m_4_burst), .m_8_burst(m_8_burst),
    .m_ack(m_ack), .m_err(m_err),
    .owb_cyc(owb_cyc), .owb_stb(owb_stb), .owb_we(owb_we), .owb_adr(owb_adr),
    .owb_o_dat(owb_o_dat), .owb_sel(owb_sel),
    .owb_4_burst(owb_4_burst), .owb_8_burst(owb_8_burst),
    .owb_ack(owb_ack), .owb_err(owb_err),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_master(input int k, input logic cyc, input logic [ADDR_W-1:0] adr);
    m_cyc[k] = cyc;
    m_stb[k] = cyc;
    m_adr[k*ADDR_W +: ADDR_W] = adr;
  endtask

  task automatic release_all();
    m_cyc = 3'b000; m_stb = 3'b000; m_4_burst = 3'b000; m_8_burst = 3'b000;
    owb_ack = 1'b0; owb_err = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int order [4];
    int g;
    order = '{0, 1, 2, 0};
    i_rst = 1'b1;
    m_cyc = 0; m_stb = 0; m_we = 0; m_adr = 0; m_o_dat = 0; m_sel = 0;
    m_4_burst = 0; m_8_burst = 0; owb_ack = 0; owb_err = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_grant", 32'(o_grant), 3);
    check("rst_cyc", 32'(owb_cyc), 0);
    check("rst_ack_err", 32'({m_ack, m_err}), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    tick();
    i_rst = 1'b0;

    // ---- single request from m1, slave acks two cycles into the tenure
    tick();
    set_master(1, 1'b1, 24'h000100);
    m_we[1] = 1'b1; m_o_dat[DATA_W +: DATA_W] = 16'hBEEF; m_sel[SEL_W +: SEL_W] = 2'b11;
    settle();
    check("single_idle_cyc", 32'(owb_cyc), 0);
    tick(); settle();
    check("single_cyc", 32'(owb_cyc), 1);
    check("single_adr", 32'(owb_adr), 32'h100);
    check("single_dat", 32'(owb_o_dat), 32'hBEEF);
    check("single_we", 32'(owb_we), 1);
    check("single_grant", 32'(o_grant), 1);
    check("single_noack", 32'(m_ack), 0);
    tick(); settle();
    check("single_wait", 32'(m_ack), 0);
    tick();
    owb_ack = 1'b1;
    settle();
    check("single_ack", 32'(m_ack), 32'b010);
    tick();
    owb_ack = 1'b0; m_we[1] = 1'b0;
    set_master(1, 1'b0, 24'h000100);
    settle();
    check("single_drop_cyc", 32'(owb_cyc), 0);
    check("single_drop_grant", 32'(o_grant), 1);
    tick(); settle();
    check("single_idle_grant", 32'(o_grant), 3);
    $display("single request done");

    // ---- three-way contention from reset, expected order 0,1,2,0
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) set_master(k, 1'b1, 24'(32'h10 * (k + 1)));
    tick();
    for (int t = 0; t < 4; t++) begin
      g = order[t];
      check("rr_grant", 32'(o_grant), 32'(g));
      check("rr_cyc", 32'(owb_cyc), 1);
      check("rr_adr", 32'(owb_adr), 32'(32'h10 * (g + 1)));
      owb_ack = 1'b1;
      settle();
      check("rr_ack", 32'(m_ack), 32'(1 << g));
      tick();
      owb_ack = 1'b0;
      m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
      settle();
      check("rr_gap_drop", 32'(owb_cyc), 0);
      tick();
      m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
      settle();
      check("rr_gap_idle_cyc", 32'(owb_cyc), 0);
      check("rr_gap_idle_grant", 32'(o_grant), 3);
      tick();
      $display("contention tenure %0d granted to m%0d", t, g);
    end
    release_all();

    // ---- 8-beat burst from m0 while m1 requests continuously
    tick();
    set_master(0, 1'b1, 24'h002000);
    m_8_burst[0] = 1'b1;
    tick();
    set_master(1, 1'b1, 24'h003000);
    for (int b = 0; b < 8; b++) begin
      owb_ack = 1'b1;
      settle();
      check("burst_ack", 32'(m_ack), 32'b001);
      check("burst_grant", 32'(o_grant), 0);
      check("burst_flag", 32'(owb_8_burst), 1);
      tick();
    end
    owb_ack = 1'b0;
    set_master(0, 1'b0, 24'h002000);
    m_8_burst[0] = 1'b0;
    settle();
    check("burst_drop_cyc", 32'(owb_cyc), 0);
    check("burst_drop_grant", 32'(o_grant), 0);
    tick(); settle();
    check("burst_idle_grant", 32'(o_grant), 3);
    tick(); settle();
    check("burst_next_grant", 32'(o_grant), 1);
    check("burst_next_adr", 32'(owb_adr), 32'h3000);
    check("burst_next_flag", 32'(owb_8_burst), 0);
    release_all();
    $display("burst hold done");

    // ---- watchdog: m2 strobes, slave silent
    tick();
    set_master(2, 1'b1, 24'h00A000);
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      settle();
      check("wd_wait_err", 32'({m_err, o_timeout}), 0);
      check("wd_wait_stb", 32'(owb_stb), 1);
      tick();
    end
    check("wd_fire_err", 32'(m_err), 32'b100);
    check("wd_fire_pulse", 32'(o_timeout), 1);
    check("wd_fire_cyc", 32'(owb_cyc), 0);
    check("wd_fire_grant", 32'(o_grant), 2);
    tick(); settle();
    check("wd_abort_err", 32'({m_err, o_timeout}), 0);
    check("wd_abort_cyc", 32'(owb_cyc), 0);
    check("wd_abort_grant", 32'(o_grant), 2);
    set_master(2, 1'b0, 24'h00A000);
    settle();
    check("wd_abort_hold", 32'(o_grant), 2);
    tick(); settle();
    check("wd_idle_grant", 32'(o_grant), 3);
    $display("watchdog fire done");

    // ---- late ack in the firing cycle wins over the watchdog
    tick();
    set_master(2, 1'b1, 24'h00B000);
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      settle();
      check("race_wait_err", 32'(m_err), 0);
      tick();
    end
    owb_ack = 1'b1;
    settle();
    check("race_ack", 32'(m_ack), 32'b100);
    check("race_ack_err", 32'(m_err), 0);
    tick();
    owb_ack = 1'b0;
    settle();
    check("race_no_timeout", 32'(o_timeout), 0);
    check("race_no_err", 32'(m_err), 0);
    check("race_grant", 32'(o_grant), 2);
    check("race_still_own", 32'(owb_cyc), 1);
    release_all();
    $display("late ack race done");

    // ---- async reset on beat 3 of an m1 4-beat burst
    tick();
    set_master(1, 1'b1, 24'h00C000);
    m_4_burst[1] = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      owb_ack = 1'b1;
      settle();
      check("rb_ack", 32'(m_ack), 32'b010);
      tick();
    end
    settle();
    check("rb_flag", 32'(owb_4_burst), 1);
    i_rst = 1'b1;
    settle();
    check("rb_rst_cyc", 32'(owb_cyc), 0);
    check("rb_rst_stb", 32'(owb_stb), 0);
    check("rb_rst_grant", 32'(o_grant), 3);
    check("rb_rst_ack", 32'(m_ack), 0);
    tick();
    owb_ack = 1'b0;
    set_master(0, 1'b1, 24'h00D000);
    i_rst = 1'b0;
    settle();
    check("rb_rel_grant", 32'(o_grant), 3);
    tick(); settle();
    check("rb_first_grant", 32'(o_grant), 0);
    check("rb_first_adr", 32'(owb_adr), 32'hD000);
    release_all();
    $display("async reset mid-burst done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
